// File: rtl/ecc_decoder.sv
// Two-stage Hamming SEC decoder for the cache read path: syndrome in stage 1,
// position decode and single-bit correction in stage 2, plus saturating error counters.
module ecc_decoder #(
   parameter int DATA_W = 32,
   parameter int CODE_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CODE_W-1:0] i_code,
   input  logic              i_vld,
   input  logic              i_cnt_clr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_vld,
   output logic              o_err_corr,
   output logic              o_err_uncorr,
   output logic [CODE_W-1:0] o_syndrome,
   output logic [CNT_W-1:0]  o_corr_cnt,
   output logic [CNT_W-1:0]  o_uncorr_cnt
);

   localparam int LAST_POS = DATA_W + CODE_W;

   // Codeword position of data bit j: the j-th non-power-of-two position from 3 upward.
   function automatic int data_pos(input int j);
      int cnt;
      data_pos = 0;
      cnt      = 0;
      for (int p = 1; p <= LAST_POS; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == j) data_pos = p;
            cnt++;
         end
      end
   endfunction

   function automatic logic [CODE_W-1:0] calc_code(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] c;
      int                pos;
      c = '0;
      for (int j = 0; j < DATA_W; j++) begin
         pos = data_pos(j);
         for (int k = 0; k < CODE_W; k++) begin
            if (pos[k]) c[k] = c[k] ^ d[j];
         end
      end
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic [DATA_W-1:0] data_p1;
   logic [CODE_W-1:0] syn_p1;
   logic              vld_p1;

   logic [DATA_W-1:0] corr_data;
   logic              uncorr;
   logic              corr;

   // Stage 1: capture data and syndrome
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_p1 <= '0;
         syn_p1  <= '0;
         vld_p1  <= 1'b0;
      end else begin
         data_p1 <= i_data;
         syn_p1  <= i_code ^ calc_code(i_data);
         vld_p1  <= i_vld;
      end
   end

   // Clean and check-bit syndromes never match a data position, so only data hits flip.
   always_comb begin
      corr_data = data_p1;
      uncorr    = (int'(syn_p1) > LAST_POS);
      corr      = (syn_p1 != '0) && !uncorr;
      for (int j = 0; j < DATA_W; j++) begin
         if (data_pos(j) == int'(syn_p1)) corr_data[j] = ~data_p1[j];
      end
   end

   // Stage 2: corrected word and valid-qualified flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_data       <= '0;
         o_syndrome   <= '0;
         o_vld        <= 1'b0;
         o_err_corr   <= 1'b0;
         o_err_uncorr <= 1'b0;
      end else begin
         o_data       <= corr_data;
         o_syndrome   <= syn_p1;
         o_vld        <= vld_p1;
         o_err_corr   <= vld_p1 & corr;
         o_err_uncorr <= vld_p1 & uncorr;
      end
   end

   // Counters: one cycle behind stage 2; clear wins over a same-cycle increment
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_corr_cnt   <= '0;
         o_uncorr_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_corr_cnt   <= '0;
         o_uncorr_cnt <= '0;
      end else begin
         if (o_vld && o_err_corr)   o_corr_cnt   <= sat_inc(o_corr_cnt);
         if (o_vld && o_err_uncorr) o_uncorr_cnt <= sat_inc(o_uncorr_cnt);
      end
   end

endmodule
